// File: rtl/ssd1289_pkg.sv
// Shared constants and types for the SSD1289 bus target: register indices,
// cursor/window types and the GRAM cursor auto-increment rule.
package ssd1289_pkg;

  localparam int X_W = 8;
  localparam int Y_W = 9;

  localparam logic [7:0] R00 = 8'h00;
  localparam logic [7:0] R22 = 8'h22;
  localparam logic [7:0] R44 = 8'h44;
  localparam logic [7:0] R45 = 8'h45;
  localparam logic [7:0] R46 = 8'h46;
  localparam logic [7:0] R4E = 8'h4E;
  localparam logic [7:0] R4F = 8'h4F;

  localparam logic [15:0] DEVICE_CODE = 16'h8989;

  // What a decoded write strobe means for the register file.
  typedef enum logic [1:0] {
    EV_NONE,
    EV_INDEX,
    EV_PIXEL,
    EV_REG
  } bus_ev_e;

  // GRAM window: horizontal start/end, vertical start/end.
  typedef struct packed {
    logic [X_W-1:0] hsa;
    logic [X_W-1:0] hea;
    logic [Y_W-1:0] vsa;
    logic [Y_W-1:0] vea;
  } window_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } cursor_t;

  // Cursor position after one GRAM beat: walk right to HEA, then wrap to HSA
  // on the next row; the row wraps from VEA back to VSA.
  function automatic cursor_t next_cursor(input cursor_t cur, input window_t win);
    cursor_t nxt;
    nxt = cur;
    if (cur.x >= win.hea) begin
      nxt.x = win.hsa;
      nxt.y = (cur.y >= win.vea) ? win.vsa : cur.y + Y_W'(1);
    end else begin
      nxt.x = cur.x + X_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ssd1289_bus_sync.sv
// Bus input synchronizer and strobe edge detection. CS/DC/WR/RD/DATA all go
// through the same number of flops so DATA stays aligned with WR. All outputs
// are registered one stage after the synchronizer.
module ssd1289_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        bus_cs,
  input  logic        bus_dc,
  input  logic        bus_wr,
  input  logic        bus_rd,
  input  logic [15:0] bus_data,
  output logic        wr_evt,
  output logic        rd_evt,
  output logic        rd_act,
  output logic        conflict,
  output logic        dc,
  output logic [15:0] data
);

  logic [SYNC_STAGES-1:0]       cs_sr;
  logic [SYNC_STAGES-1:0]       dc_sr;
  logic [SYNC_STAGES-1:0]       wr_sr;
  logic [SYNC_STAGES-1:0]       rd_sr;
  logic [SYNC_STAGES-1:0][15:0] data_sr;

  logic cs_s, dc_s, wr_s, rd_s;
  logic [15:0] data_s;
  logic wr_prev, rd_prev, wr_armed;
  logic wr_rise, rd_fall;

  assign cs_s   = cs_sr[SYNC_STAGES-1];
  assign dc_s   = dc_sr[SYNC_STAGES-1];
  assign wr_s   = wr_sr[SYNC_STAGES-1];
  assign rd_s   = rd_sr[SYNC_STAGES-1];
  assign data_s = data_sr[SYNC_STAGES-1];

  // A write completes only if its whole low phase saw CS low; CS going high
  // at any point abandons the strobe until WR returns high.
  assign wr_rise = wr_s && !wr_prev && wr_armed && !cs_s;
  assign rd_fall = !rd_s && rd_prev && !cs_s && wr_s;

  // Synchronizer shift chains; strobes idle high.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sr   <= '1;
      dc_sr   <= '0;
      wr_sr   <= '1;
      rd_sr   <= '1;
      // NOTE: the DATA chain is reset too, so nothing downstream ever sees X
      // even though its value only matters when qualified by a strobe.
      data_sr <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage take the previous
      // stage's old value, which is what turns this into a shift chain.
      cs_sr   <= {cs_sr[SYNC_STAGES-2:0], bus_cs};
      dc_sr   <= {dc_sr[SYNC_STAGES-2:0], bus_dc};
      wr_sr   <= {wr_sr[SYNC_STAGES-2:0], bus_wr};
      rd_sr   <= {rd_sr[SYNC_STAGES-2:0], bus_rd};
      data_sr <= {data_sr[SYNC_STAGES-2:0], bus_data};
    end
  end

  // Edge history and write-strobe qualification against CS going high.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_prev  <= 1'b1;
      rd_prev  <= 1'b1;
      wr_armed <= 1'b0;
    end else begin
      wr_prev <= wr_s;
      rd_prev <= rd_s;
      if (wr_s) begin
        wr_armed <= 1'b0;
      end else if (wr_prev) begin
        wr_armed <= !cs_s;
      end else if (cs_s) begin
        wr_armed <= 1'b0;
      end
    end
  end

  // Registered event/status outputs with DC and DATA kept in step.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_evt   <= 1'b0;
      rd_evt   <= 1'b0;
      rd_act   <= 1'b0;
      conflict <= 1'b0;
      dc       <= 1'b0;
      data     <= '0;
    end else begin
      wr_evt   <= wr_rise;
      rd_evt   <= rd_fall;
      rd_act   <= !rd_s && !cs_s && wr_s;
      conflict <= !rd_s && !wr_s && !cs_s;
      dc       <= dc_s;
      data     <= data_s;
    end
  end

endmodule

// File: rtl/ssd1289_bus_target.sv
// SSD1289 8080-bus target: index/data write decode, window and cursor
// shadows, GRAM pixel beats with auto-increment, and register read-back.
module ssd1289_bus_target
  import ssd1289_pkg::*;
#(
  parameter int size_x      = 240,
  parameter int size_y      = 320,
  parameter int SYNC_STAGES = 2
) (
  input  logic           sys_clk,
  input  logic           rst_n,
  input  logic           bus_CS,
  input  logic           bus_DC,
  input  logic           bus_WR,
  input  logic           bus_RD,
  input  logic [15:0]    bus_DATA,
  output logic [15:0]    bus_DOUT,
  output logic           bus_DOE,
  output logic           pix_valid,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic [15:0]    pix_data,
  output logic           gram_start,
  output logic           reg_valid,
  output logic [7:0]     reg_index,
  output logic [15:0]    reg_data,
  output logic           proto_err
);

  localparam logic [X_W-1:0] HEA_RST = X_W'(size_x - 1);
  localparam logic [Y_W-1:0] VEA_RST = Y_W'(size_y - 1);

  logic        wr_evt, rd_evt, rd_act, conflict, dc;
  logic [15:0] data;

  logic [7:0]  index_q;
  window_t     win_q;
  cursor_t     cur_q;
  logic        doe_q;
  logic [15:0] rd_value;
  bus_ev_e     ev;

  ssd1289_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .bus_cs   (bus_CS),
    .bus_dc   (bus_DC),
    .bus_wr   (bus_WR),
    .bus_rd   (bus_RD),
    .bus_data (bus_DATA),
    .wr_evt   (wr_evt),
    .rd_evt   (rd_evt),
    .rd_act   (rd_act),
    .conflict (conflict),
    .dc       (dc),
    .data     (data)
  );

  // Classify each completed write strobe.
  always_comb begin
    // NOTE: assigning the default first means every path drives ev, so no
    // latch is inferred.
    ev = EV_NONE;
    if (wr_evt) begin
      if (!dc) begin
        ev = EV_INDEX;
      end else if (index_q == R22) begin
        ev = EV_PIXEL;
      end else begin
        ev = EV_REG;
      end
    end
  end

  // Read mux: shadow value of the currently selected index.
  always_comb begin
    rd_value = '0;
    case (index_q)
      R00:     rd_value = DEVICE_CODE;
      R44:     rd_value = {win_q.hea, win_q.hsa};
      R45:     rd_value = 16'(win_q.vsa);
      R46:     rd_value = 16'(win_q.vea);
      R4E:     rd_value = 16'(cur_q.x);
      R4F:     rd_value = 16'(cur_q.y);
      default: rd_value = '0;
    endcase
  end

  // Index register, window shadows and the GRAM cursor.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      index_q   <= '0;
      win_q.hsa <= '0;
      win_q.hea <= HEA_RST;
      win_q.vsa <= '0;
      win_q.vea <= VEA_RST;
      cur_q     <= '0;
    end else begin
      case (ev)
        EV_INDEX: index_q <= data[7:0];
        EV_PIXEL: cur_q   <= next_cursor(cur_q, win_q);
        EV_REG: begin
          case (index_q)
            R44: begin
              win_q.hea <= data[15:8];
              win_q.hsa <= data[7:0];
            end
            R45:     win_q.vsa <= data[Y_W-1:0];
            R46:     win_q.vea <= data[Y_W-1:0];
            R4E:     cur_q.x   <= data[X_W-1:0];
            R4F:     cur_q.y   <= data[Y_W-1:0];
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // One-cycle event pulses and their held payloads.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_data   <= '0;
      gram_start <= 1'b0;
      reg_valid  <= 1'b0;
      reg_index  <= '0;
      reg_data   <= '0;
    end else begin
      pix_valid  <= (ev == EV_PIXEL);
      gram_start <= (ev == EV_INDEX) && (data[7:0] == R22);
      reg_valid  <= (ev == EV_REG);
      if (ev == EV_PIXEL) begin
        pix_x    <= cur_q.x;
        pix_y    <= cur_q.y;
        pix_data <= data;
      end
      if (ev == EV_REG) begin
        reg_index <= index_q;
        reg_data  <= data;
      end
    end
  end

  // Read port: data is captured at the RD fall; the enable is armed by that
  // capture and dropped as soon as the read stops being active.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_DOUT  <= '0;
      doe_q     <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (rd_evt) begin
        bus_DOUT <= rd_value;
      end
      if (!rd_act) begin
        doe_q <= 1'b0;
      end else if (rd_evt) begin
        doe_q <= 1'b1;
      end
      if (conflict) begin
        proto_err <= 1'b1;
      end
    end
  end

  // Gating with rd_act lets the enable fall one cycle sooner than it rises.
  assign bus_DOE = doe_q && rd_act;

endmodule

// File: tb/tb_ssd1289_bus_target.sv
// Directed bench for ssd1289_bus_target: drives 8080 bus cycles and checks
// decoded events, cursor walking, read-back, protocol errors and reset.
module tb_ssd1289_bus_target;

  localparam int SYNC_STAGES = 2;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        bus_CS, bus_DC, bus_WR, bus_RD;
  logic [15:0] bus_DATA;
  logic [15:0] bus_DOUT;
  logic        bus_DOE;
  logic        pix_valid;
  logic [7:0]  pix_x;
  logic [8:0]  pix_y;
  logic [15:0] pix_data;
  logic        gram_start;
  logic        reg_valid;
  logic [7:0]  reg_index;
  logic [15:0] reg_data;
  logic        proto_err;

  always #5 sys_clk = ~sys_clk;

  ssd1289_bus_target #(
    .size_x      (240),
    .size_y      (320),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .bus_CS     (bus_CS),
    .bus_DC     (bus_DC),
    .bus_WR     (bus_WR),
    .bus_RD     (bus_RD),
    .bus_DATA   (bus_DATA),
    .bus_DOUT   (bus_DOUT),
    .bus_DOE    (bus_DOE),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_data   (pix_data),
    .gram_start (gram_start),
    .reg_valid  (reg_valid),
    .reg_index  (reg_index),
    .reg_data   (reg_data),
    .proto_err  (proto_err)
  );

  typedef struct {
    logic [7:0]  x;
    logic [8:0]  y;
    logic [15:0] d;
    int          cyc;
  } pix_t;

  typedef struct {
    logic [7:0]  idx;
    logic [15:0] d;
  } reg_t;

  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc = 0;
  int   gs_cnt = 0;
  int   last_rise = 0;
  pix_t pix_q[$];
  reg_t reg_q[$];

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Event monitor, sampled mid-cycle.
  always @(negedge sys_clk) begin
    if (rst_n) begin
      if (pix_valid) pix_q.push_back('{pix_x, pix_y, pix_data, cyc});
      if (reg_valid) reg_q.push_back('{reg_index, reg_data});
      if (gram_start) gs_cnt++;
    end
  end

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic clear_log();
    pix_q.delete();
    reg_q.delete();
    gs_cnt = 0;
  endtask

  task automatic bus_write(input logic dc, input logic [15:0] d);
    bus_CS   = 1'b0;
    bus_DC   = dc;
    bus_DATA = d;
    bus_WR   = 1'b0;
    idle(4);
    bus_WR    = 1'b1;
    last_rise = cyc;
    idle(6);
  endtask

  task automatic bus_read(input string tag, input logic [15:0] exp, input bit check_lat);
    int first;
    bus_CS = 1'b0;
    bus_RD = 1'b0;
    first  = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge sys_clk);
      if (bus_DOE && first < 0) first = k;
    end
    check({tag, " doe"}, 48'(bus_DOE), 48'(1));
    check({tag, " dout"}, 48'(bus_DOUT), 48'(exp));
    // First sampling edge is one cycle after the drive, then SYNC_STAGES+1.
    if (check_lat) check({tag, " doe rise"}, 48'(first), 48'(SYNC_STAGES + 2));
    bus_RD = 1'b1;
    first  = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge sys_clk);
      if (!bus_DOE && first < 0) first = k;
    end
    if (check_lat) check({tag, " doe fall"}, 48'(first), 48'(SYNC_STAGES + 1));
  endtask

  task automatic check_pix(input string tag, input int i, input logic [7:0] x,
                           input logic [8:0] y, input logic [15:0] d);
    check({tag, " present"}, 48'(i < pix_q.size()), 48'(1));
    if (i < pix_q.size())
      check(tag, 48'({pix_q[i].x, pix_q[i].y, pix_q[i].d}), 48'({x, y, d}));
  endtask

  task automatic check_reg(input string tag, input int i, input logic [7:0] idx,
                           input logic [15:0] d);
    check({tag, " present"}, 48'(i < reg_q.size()), 48'(1));
    if (i < reg_q.size())
      check(tag, 48'({reg_q[i].idx, reg_q[i].d}), 48'({idx, d}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] wx [6];
    logic [8:0] wy [6];
    wx = '{8'd2, 8'd3, 8'd2, 8'd3, 8'd2, 8'd3};
    wy = '{9'd1, 9'd1, 9'd2, 9'd2, 9'd1, 9'd1};

    rst_n    = 1'b0;
    bus_CS   = 1'b1;
    bus_DC   = 1'b0;
    bus_WR   = 1'b1;
    bus_RD   = 1'b1;
    bus_DATA = 16'h0000;
    idle(3);
    check("rst doe", 48'(bus_DOE), 48'(0));
    check("rst dout", 48'(bus_DOUT), 48'(0));
    check("rst pulses", 48'({pix_valid, reg_valid, gram_start}), 48'(0));
    check("rst pix", 48'({pix_x, pix_y, pix_data}), 48'(0));
    check("rst reg", 48'({reg_index, reg_data}), 48'(0));
    check("rst proto_err", 48'(proto_err), 48'(0));
    rst_n = 1'b1;
    idle(3);

    // Device code and reset window; upper byte of an index write is ignored.
    bus_write(1'b0, 16'hAB00);
    bus_read("r00", 16'h8989, 1'b1);
    bus_write(1'b0, 16'h0044);
    bus_read("r44 reset", 16'hEF00, 1'b0);

    // Cursor set, then two GRAM beats.
    clear_log();
    bus_write(1'b0, 16'h004E);
    bus_write(1'b1, 16'h0005);
    bus_write(1'b0, 16'h004F);
    bus_write(1'b1, 16'h0007);
    bus_write(1'b0, 16'h0022);
    bus_write(1'b1, 16'hF800);
    check("pix present for latency", 48'(pix_q.size()), 48'(1));
    if (pix_q.size() > 0)
      check("pix latency", 48'(pix_q[0].cyc - last_rise), 48'(SYNC_STAGES + 2));
    bus_write(1'b1, 16'h07E0);
    check("gram_start count", 48'(gs_cnt), 48'(1));
    check("pix count", 48'(pix_q.size()), 48'(2));
    check_pix("pix0", 0, 8'd5, 9'd7, 16'hF800);
    check_pix("pix1", 1, 8'd6, 9'd7, 16'h07E0);
    check("reg count", 48'(reg_q.size()), 48'(2));
    check_reg("reg r4e", 0, 8'h4E, 16'h0005);
    check_reg("reg r4f", 1, 8'h4F, 16'h0007);

    // Small window 2..3 x 1..2: walks and wraps in both directions.
    bus_write(1'b0, 16'h0044); bus_write(1'b1, 16'h0302);
    bus_write(1'b0, 16'h0045); bus_write(1'b1, 16'h0001);
    bus_write(1'b0, 16'h0046); bus_write(1'b1, 16'h0002);
    bus_write(1'b0, 16'h004E); bus_write(1'b1, 16'h0002);
    bus_write(1'b0, 16'h004F); bus_write(1'b1, 16'h0001);
    bus_write(1'b0, 16'h0022);
    clear_log();
    for (int i = 0; i < 6; i++) bus_write(1'b1, 16'h0100 + 16'(i));
    check("win pix count", 48'(pix_q.size()), 48'(6));
    for (int i = 0; i < 6; i++)
      check_pix($sformatf("win pix%0d", i), i, wx[i], wy[i], 16'h0100 + 16'(i));
    bus_read("r22", 16'h0000, 1'b0);
    bus_write(1'b0, 16'h004E); bus_read("r4e wrap", 16'h0002, 1'b0);
    bus_write(1'b0, 16'h004F); bus_read("r4f wrap", 16'h0002, 1'b0);
    bus_write(1'b0, 16'h0045); bus_read("r45", 16'h0001, 1'b0);
    bus_write(1'b0, 16'h0046); bus_read("r46", 16'h0002, 1'b0);
    bus_write(1'b0, 16'h0044); bus_read("r44", 16'h0302, 1'b0);

    // Strobes with CS high, and CS bouncing high mid-strobe, are dropped.
    bus_write(1'b0, 16'h004E);
    clear_log();
    bus_CS = 1'b1; bus_DC = 1'b1; bus_DATA = 16'h0055; bus_WR = 1'b0;
    idle(4);
    bus_WR = 1'b1;
    idle(6);
    bus_CS = 1'b0; bus_DATA = 16'h0066; bus_WR = 1'b0;
    idle(4);
    bus_CS = 1'b1;
    idle(4);
    bus_CS = 1'b0;
    idle(4);
    bus_WR = 1'b1;
    idle(6);
    check("cs-high events", 48'(reg_q.size() + pix_q.size()), 48'(0));
    bus_write(1'b1, 16'h0009);
    check("r4e=9 count", 48'(reg_q.size()), 48'(1));
    check_reg("r4e=9", 0, 8'h4E, 16'h0009);
    bus_read("r4e=9 rd", 16'h0009, 1'b0);

    // CS rising during a read drops the enable.
    bus_RD = 1'b0;
    idle(6);
    check("rd before cs rise", 48'(bus_DOE), 48'(1));
    bus_CS = 1'b1;
    idle(4);
    check("rd after cs rise", 48'(bus_DOE), 48'(0));
    bus_RD = 1'b1;
    bus_CS = 1'b0;
    idle(6);

    // WR and RD low together: error flag, no read, write still lands.
    bus_write(1'b0, 16'h004F);
    clear_log();
    bus_DC = 1'b1; bus_DATA = 16'h0033; bus_WR = 1'b0; bus_RD = 1'b0;
    idle(6);
    check("conflict proto_err", 48'(proto_err), 48'(1));
    check("conflict doe", 48'(bus_DOE), 48'(0));
    bus_WR = 1'b1; bus_RD = 1'b1;
    idle(6);
    check("conflict write count", 48'(reg_q.size()), 48'(1));
    check_reg("conflict write", 0, 8'h4F, 16'h0033);
    bus_read("r4f after err", 16'h0033, 1'b0);
    bus_write(1'b0, 16'h004E);
    bus_read("r4e after err", 16'h0009, 1'b0);
    check("proto_err sticky", 48'(proto_err), 48'(1));

    // Cursor outside the window wraps to (HSA,VSA); reset mid-burst.
    bus_write(1'b0, 16'h004E); bus_write(1'b1, 16'd10);
    bus_write(1'b0, 16'h004F); bus_write(1'b1, 16'd20);
    bus_write(1'b0, 16'h0022);
    clear_log();
    bus_write(1'b1, 16'hAAAA);
    bus_write(1'b1, 16'hBBBB);
    check_pix("out-of-window pix", 0, 8'd10, 9'd20, 16'hAAAA);
    check_pix("wrapped pix", 1, 8'd2, 9'd1, 16'hBBBB);
    bus_DC = 1'b1; bus_DATA = 16'hCCCC; bus_WR = 1'b0;
    idle(2);
    #3 rst_n = 1'b0;
    #1;
    check("mid rst pix", 48'({pix_valid, pix_x, pix_y, pix_data}), 48'(0));
    check("mid rst reg", 48'({reg_valid, reg_index, reg_data}), 48'(0));
    check("mid rst read", 48'({bus_DOE, bus_DOUT}), 48'(0));
    check("mid rst proto_err", 48'(proto_err), 48'(0));
    idle(2);
    bus_WR = 1'b1;
    bus_CS = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(3);
    check("no beat after rst", 48'(pix_q.size()), 48'(2));
    bus_write(1'b0, 16'h004E); bus_read("x after rst", 16'h0000, 1'b0);
    bus_write(1'b0, 16'h004F); bus_read("y after rst", 16'h0000, 1'b0);
    bus_write(1'b0, 16'h0044); bus_read("r44 after rst", 16'hEF00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
